// File: rtl/rr_mux_select_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter.
// FSM encodings, default sizes and hold-counter width.
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_TURN  = 2'b10
  } state_e;

  localparam int ARB_NUM_REQ   = 32;
  localparam int ARB_SEL_WIDTH = 5;
  localparam int HOLD_W        = 8;

endpackage

// File: rtl/rr_mux_select_arbiter_pick.sv
// Combinational round-robin winner search starting at ptr.
// Rotate right by ptr, find first set, add ptr back mod NUM_REQ.
module rr_priority_pick
  import arb_defs::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int SEL_WIDTH = ARB_SEL_WIDTH
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [SEL_WIDTH-1:0] win_o,
  output logic                 any_o
);

  localparam logic [SEL_WIDTH:0] NUM_W = (SEL_WIDTH+1)'(NUM_REQ);

  logic [NUM_REQ-1:0]   rot;
  logic [SEL_WIDTH-1:0] off;
  logic [SEL_WIDTH:0]   sum;

  // rotate so that requester ptr lands at bit 0
  always_comb begin
    int idx;
    idx = 0;
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = i + int'(ptr_i);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      rot[i] = req_i[idx];
    end
  end

  // lowest set bit of the rotated vector
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_WIDTH'(i);
    end
  end

  assign sum   = {1'b0, off} + {1'b0, ptr_i};
  assign win_o = (sum >= NUM_W) ? SEL_WIDTH'(sum - NUM_W)
                                : sum[SEL_WIDTH-1:0];
  assign any_o = |req_i;

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin owner arbiter driving a shared 32:1 mux select.
// Optional hold limit compiled in with ARB_HOLD_TIMEOUT_EN.
module rr_mux_select_arbiter
  import arb_defs::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int SEL_WIDTH = ARB_SEL_WIDTH,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic                 DONE,
  output logic [NUM_REQ-1:0]   GNT,
  output logic [SEL_WIDTH-1:0] SEL,
  output logic                 VALID,
  output logic                 TIMEOUT
);

  if (NUM_REQ < 2 || NUM_REQ > 32 ||
      SEL_WIDTH != $clog2(NUM_REQ) ||
      MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("rr_mux_select_arbiter: illegal parameters");
  end

  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   ONE  = NUM_REQ'(1);

  state_e state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic [SEL_WIDTH-1:0] win;
  logic                 any_req;
  logic                 own_req;
  logic                 rel_user;
  logic                 release_c;

  rr_priority_pick #(
    .NUM_REQ   (NUM_REQ),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  assign own_req  = REQ[sel_q];
  assign rel_user = DONE | ~own_req;

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              to_q, to_d;
  logic              hold_hit;

  assign hold_hit  = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign release_c = rel_user | hold_hit;
  assign TIMEOUT   = to_q;
`else
  assign release_c = rel_user;
  assign TIMEOUT   = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // next-state: IDLE -> GRANT -> TURN -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_GRANT;
      ST_GRANT: if (release_c) state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // next values for grant, select, pointer and hold tracking
  always_comb begin
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (any_req) begin
          gnt_d   = ONE << win;
          sel_d   = win;
          valid_d = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = (sel_q == LAST) ? '0
                                    : sel_q + SEL_WIDTH'(1);
`ifdef ARB_HOLD_TIMEOUT_EN
          to_d    = hold_hit & ~rel_user;
`endif
        end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
          if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // output and pointer registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  // hold counter and timeout pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_q <= '0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      to_q   <= to_d;
    end
  end
`endif

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Directed scoreboard bench for rr_mux_select_arbiter.
// Hold-limit steps run only when ARB_HOLD_TIMEOUT_EN is defined.
module tb_rr_mux_select_arbiter;

  localparam int N  = 32;
  localparam int SW = 5;
  localparam int MH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  REQ;
  logic          DONE;
  logic [N-1:0]  GNT;
  logic [SW-1:0] SEL;
  logic          VALID;
  logic          TIMEOUT;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] gnt;
    logic [SW-1:0] sel;
    logic         valid;
    logic         to;
  } exp_t;

  exp_t sb[$];

  rr_mux_select_arbiter #(
    .NUM_REQ   (N),
    .SEL_WIDTH (SW),
    .MAX_HOLD  (MH)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .DONE    (DONE),
    .GNT     (GNT),
    .SEL     (SEL),
    .VALID   (VALID),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // owner < 0 means no grant expected
  task automatic push(string tag, int owner, int sel, bit to);
    exp_t e;
    e.tag   = tag;
    e.gnt   = (owner < 0) ? '0 : (N'(1) << owner);
    e.valid = (owner >= 0);
    e.sel   = SW'(sel);
    e.to    = to;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".gnt"}, GNT, e.gnt);
    chk({e.tag, ".sel"}, N'(SEL), N'(e.sel));
    chk({e.tag, ".valid"}, N'(VALID), N'(e.valid));
    chk({e.tag, ".timeout"}, N'(TIMEOUT), N'(e.to));
  endtask

  task automatic now(string tag, int owner, int sel, bit to);
    push(tag, owner, sel, to);
    pop_cmp();
  endtask

  task automatic step(string tag, int owner, int sel, bit to);
    push(tag, owner, sel, to);
    @(posedge CLK);
    #1;
    pop_cmp();
  endtask

  // structural invariants sampled every falling edge
  always @(negedge CLK) begin
    chk("inv.onehot", N'($onehot0(GNT)), N'(1));
    chk("inv.gnt_sel", N'(GNT[SEL]), N'(VALID));
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int ord[4] = '{0, 2, 31, 0};

  initial begin
    RST  = 1'b0;
    REQ  = '0;
    DONE = 1'b0;
    #1;
    now("reset", -1, 0, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    now("reset_hold", -1, 0, 0);

    // grant to 4, then asynchronous reset mid-grant
    RST = 1'b1;
    REQ = 32'h0000_0010;
    step("rst.g4a", 4, 4, 0);
    step("rst.g4b", 4, 4, 0);
    #2;
    RST = 1'b0;
    #1;
    now("rst.async", -1, 0, 0);
    #1;
    RST = 1'b1;
    step("rst.regrant", 4, 4, 0);
    REQ = '0;
    step("rst.turn", -1, 4, 0);
    step("rst.idle", -1, 4, 0);

    // fresh pointer, then round-robin 0 -> 2 -> 31 -> 0
    #2;
    RST = 1'b0;
    #2;
    RST = 1'b1;
    REQ = 32'h8000_0005;
    foreach (ord[k]) begin
      DONE = 1'b0;
      step($sformatf("rr%0d.g1", k), ord[k], ord[k], 0);
      step($sformatf("rr%0d.g2", k), ord[k], ord[k], 0);
      DONE = 1'b1;
      step($sformatf("rr%0d.turn", k), -1, ord[k], 0);
      DONE = 1'b0;
      if (k == 3) REQ = '0;
      step($sformatf("rr%0d.idle", k), -1, ord[k], 0);
    end
    step("rr.quiet", -1, 0, 0);

    // request drop by owner 7 with 8 pending
    REQ = 32'h0000_0180;
    step("drop.g7a", 7, 7, 0);
    step("drop.g7b", 7, 7, 0);
    REQ = 32'h0000_0100;
    step("drop.turn", -1, 7, 0);
    step("drop.idle", -1, 7, 0);
    step("drop.g8", 8, 8, 0);
    DONE = 1'b1;
    step("drop.rel8", -1, 8, 0);
    DONE = 1'b0;
    REQ  = '0;
    step("drop.idle2", -1, 8, 0);

`ifdef ARB_HOLD_TIMEOUT_EN
    // hold limit revokes after MH grant cycles
    REQ = 32'h0000_0008;
    for (int i = 0; i < MH; i++)
      step($sformatf("to.g%0d", i), 3, 3, 0);
    step("to.pulse", -1, 3, 1);
    step("to.idle", -1, 3, 0);
    step("to.regrant", 3, 3, 0);
    for (int i = 1; i < MH; i++)
      step($sformatf("sim.g%0d", i), 3, 3, 0);
    // DONE in the limit cycle: plain release
    DONE = 1'b1;
    step("sim.rel", -1, 3, 0);
    DONE = 1'b0;
    REQ  = '0;
    step("sim.idle", -1, 3, 0);
`else
    // owner holds indefinitely; late requests ignored
    REQ = 32'h0000_0008;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) REQ = 32'hFFFF_FFFF;
      step("hold.g3", 3, 3, 0);
    end
    DONE = 1'b1;
    step("hold.rel", -1, 3, 0);
    DONE = 1'b0;
    REQ  = '0;
    step("hold.idle", -1, 3, 0);
`endif

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rr_mux_select_arbiter.md
Name: rr_mux_select_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit wide 32:1 selection datapath between up to 32 requesters.
- Drives the 5-bit select of that mux plus a one-hot grant.
- The owner holds the datapath until it signals DONE or drops its request.
- A one-cycle turn-around between owners guarantees the select never changes under a live owner.

Parameters:
- NUM_REQ, 32: number of requesters, legal range 2..32.
- SEL_WIDTH, 5: select width, must equal clog2(NUM_REQ) rounded up; 5 for the 32:1 mux.
- MAX_HOLD, 16: maximum GRANT cycles per ownership. Used only when the timeout feature is compiled in. Legal range 1..255.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-low reset.
- REQ  input  NUM_REQ  request vector, one bit per requester, level-sensitive.
- DONE  input  1  current owner releases the datapath. Sampled only in GRANT.
- GNT  output  NUM_REQ  one-hot grant. All zero when there is no owner.
- SEL  output  SEL_WIDTH  mux select, equal to the owner index.
- VALID  output  1  high while SEL addresses a granted owner.
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked. Tied 0 without the feature.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE, GNT=0, SEL=0, VALID=0, TIMEOUT=0, ptr=0, hold_cnt=0. Deassertion is used synchronously at the next CLK edge.
- State machine: IDLE -> GRANT -> TURN -> IDLE.
- IDLE:
  - If REQ is all zero, stay in IDLE and leave outputs unchanged (GNT=0, VALID=0, SEL holds its last value).
  - Otherwise the winner is the first index i, searching ptr, ptr+1, ..., wrapping at NUM_REQ-1 to 0, with REQ[i]=1.
  - At the next edge: GNT[i]=1, SEL=i, VALID=1, hold_cnt=0, go to GRANT.
  - Latency: REQ asserted before edge t gives GNT from edge t.
- GRANT:
  - Release condition: DONE=1, or REQ[owner]=0, or (feature on) hold_cnt==MAX_HOLD-1.
  - On release, at the next edge: GNT=0, VALID=0, SEL holds, ptr=(owner+1) mod NUM_REQ, go to TURN.
  - If release is due only to the hold limit, TIMEOUT=1 for that one cycle.
  - Otherwise hold_cnt increments, saturating at its maximum.
  - Other requests arriving during GRANT are ignored and do not change GNT or SEL.
- TURN:
  - Exactly one cycle with GNT=0 and VALID=0.
  - Always go to IDLE. Arbitration is not done in this state.
  - Minimum back-to-back handover: GRANT(A) last cycle, TURN, IDLE, GRANT(B). That is 2 dead cycles.
- Simultaneous events:
  - DONE and the timeout in the same cycle: normal release, TIMEOUT=0.
  - DONE with REQ[owner] still high: still a release. The owner re-arbitrates behind the others.
- Wrap-around: owner NUM_REQ-1 gives ptr=0. A lone requester is re-granted after every TURN.
- Bits of REQ at or above NUM_REQ do not exist. SEL never exceeds NUM_REQ-1.
- Reset mid-GRANT: GNT and VALID drop immediately (asynchronously). ptr returns to 0, so fairness history is lost.
- GNT is always one-hot or zero. GNT[SEL]==VALID in every cycle.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined: hold_cnt is implemented (8 bits). A grant lasting MAX_HOLD GRANT cycles without release is revoked and TIMEOUT pulses. This prevents one requester starving the datapath.
- Not defined: hold_cnt and TIMEOUT logic are absent, TIMEOUT is tied 0, and the owner holds indefinitely until DONE or request drop.

Decomposition:
- Shared package (arb_defs):
  - State encodings ST_IDLE=2'b00, ST_GRANT=2'b01, ST_TURN=2'b10.
  - Default NUM_REQ and SEL_WIDTH constants.
  - Hold-counter width constant 8.
- One sub-module, rr_priority_pick:
  - Purely combinational.
  - Inputs: REQ and ptr. Outputs: winner index and any_req.
  - Implemented as rotate right by ptr, find-first-set, then add ptr back modulo NUM_REQ.
- The top level holds the FSM, the ptr register, hold_cnt and the output registers.

Test Plan:
- Reset: RST low mid-GRANT with REQ=32'h0000_0010 -> GNT=0, VALID=0, SEL=0 immediately, without waiting for CLK. After release, first grant goes to index 4 one edge later.
- Round-robin order: REQ=32'h8000_0005 held constant, each owner pulses DONE after 2 GRANT cycles -> owners 0, 2, 31, then 0 again (wrap). Each handover has exactly 2 cycles with GNT=0.
- Request drop: owner 7 deasserts REQ[7] with DONE=0 -> next edge GNT=0, state TURN, ptr=8. REQ[8] pending gets GNT=32'h0000_0100 two edges later.
- Timeout, with ARB_HOLD_TIMEOUT_EN and MAX_HOLD=4: REQ[3] held, DONE=0 -> GNT[3] high exactly 4 cycles, then one TIMEOUT pulse, then re-grant to 3 after TURN and IDLE.
- No timeout (macro undefined): the same stimulus for 1000 cycles -> GNT[3] stays high, TIMEOUT stays 0.
- Simultaneous: DONE=1 in the cycle hold_cnt reaches MAX_HOLD-1 -> release with TIMEOUT=0. Also check SEL==owner and one-hot GNT in every cycle via assertion.
